// File: rtl/mem_lsu.sv
// mem_lsu: RV32I load/store unit for the MEM stage. It accepts one access at a
// time, runs a req/gnt + rvalid handshake on the data bus, formats load data
// into mem_read_data and stalls the front of the pipe while the bus is busy.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_read_data,
  output logic        lsu_stall,
  output logic        lsu_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t      state;
  logic        req_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        in_idle;
  logic        bad_access;
  logic        accept;

  // Illegal width codes and misaligned halfword/word addresses.
  function automatic logic access_fault(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = rd & wr;
    if (rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) bad = 1'b1;
    if (wr && (f3 > 3'b010)) bad = 1'b1;
    if (f3[1:0] == 2'b01 && off[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && off != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Narrow stores are replicated across lanes; the byte enables pick the lane.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane select then sign/zero extension; funct3[2] marks the unsigned forms.
  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0]        byte_sh;
    logic [31:0]        half_sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    logic [31:0]        res;
    byte_sh = word >> {off, 3'b000};
    half_sh = word >> {off[1], 4'b0000};
    b  = byte_sh[7:0];
    h  = half_sh[15:0];
    sx = 32'sd0;
    res = word;
    if (f3[1:0] == 2'b00) begin
      sx  = 32'(b);
      res = f3[2] ? {24'h0, b} : sx;
    end else if (f3[1:0] == 2'b01) begin
      sx  = 32'(h);
      res = f3[2] ? {16'h0, h} : sx;
    end
    return res;
  endfunction

  assign in_idle    = (state == S_IDLE) && !rst;
  assign bad_access = access_fault(ex_mem_read, ex_mem_write, ex_funct3, ex_addr[1:0]);
  assign accept     = in_idle && (ex_mem_read ^ ex_mem_write) && !bad_access;

  assign lsu_fault  = in_idle && (ex_mem_read || ex_mem_write) && bad_access;
  assign lsu_stall  = accept || (!rst && (state == S_REQ || state == S_RESP));

  assign dmem_req      = req_q && !rst;
  assign dmem_we       = we_q;
  assign dmem_addr     = {addr_q[31:2], 2'b00};
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign mem_read_data = rdata_q;

  // Access FSM: latch on acceptance, hold the request until granted, then
  // collect load data and spend one DONE cycle before returning to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_REQ;
            req_q    <= 1'b1;
            we_q     <= ex_mem_write;
            funct3_q <= ex_funct3;
            addr_q   <= ex_addr;
            be_q     <= store_be(ex_funct3[1:0], ex_addr[1:0]);
            wdata_q  <= store_data(ex_funct3[1:0], ex_store_data);
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            req_q <= 1'b0;
            state <= we_q ? S_DONE : S_RESP;
          end
        end
        S_RESP: begin
          if (dmem_rvalid) begin
            rdata_q <= load_format(funct3_q, addr_q[1:0], dmem_rdata);
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a byte-level
// reference model of RV32I load/store width, alignment and formatting rules.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_read_data;
  logic        lsu_stall, lsu_fault;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_mrd = 32'h0;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_read_data(mem_read_data), .lsu_stall(lsu_stall), .lsu_fault(lsu_fault)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_fault(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = size_of(f3);
    if (rd && wr) return 1'b1;
    if (rd && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
    if (wr && f3 > 3'd2) return 1'b1;
    if ((int'(addr[1:0]) % sz) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be;
    int sz, off;
    sz = size_of(f3);
    off = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int sz;
    sz = size_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] v;
    int sz, off;
    sz = size_of(f3);
    off = int'(addr[1:0]);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- bus driver (returns observations, no checking) ----------------
  // Called at a falling edge in IDLE; returns at a falling edge back in IDLE.
  task automatic drive_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                              output int stall_cnt, output logic [3:0] be,
                              output logic [31:0] waddr, output logic [31:0] wdata,
                              output logic we, output logic stable,
                              output logic done_ok, output logic timeout);
    int   cnt;
    logic granted, got;
    stall_cnt = 0; stable = 1'b1; done_ok = 1'b0; timeout = 1'b0;
    be = 4'h0; waddr = 32'h0; wdata = 32'h0; we = 1'b0;
    ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3;
    ex_addr = addr; ex_store_data = sdata;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    if (lsu_stall) stall_cnt++;
    @(posedge clk); @(negedge clk);
    ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_addr = $urandom; ex_store_data = $urandom; ex_funct3 = 3'($urandom);
    cnt = 0; granted = 1'b0;
    while (!granted && !timeout) begin
      dmem_gnt = (cnt == gnt_dly);
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #1;
      if (cnt == 0) begin
        be = dmem_be; waddr = dmem_addr; wdata = dmem_wdata; we = dmem_we;
      end
      if ({dmem_req, dmem_be, dmem_addr, dmem_wdata, dmem_we} !== {1'b1, be, waddr, wdata, we})
        stable = 1'b0;
      if (lsu_stall) stall_cnt++;
      granted = dmem_gnt;
      cnt++;
      if (cnt > 40) timeout = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    dmem_gnt = 1'b0;
    if (!wr) begin
      cnt = 0; got = 1'b0;
      while (!got && !timeout) begin
        dmem_rvalid = (cnt == rv_dly);
        dmem_rdata = (cnt == rv_dly) ? rdata : $urandom;
        #1;
        if (lsu_stall) stall_cnt++;
        if (dmem_req) stable = 1'b0;
        got = dmem_rvalid;
        cnt++;
        if (cnt > 40) timeout = 1'b1;
        @(posedge clk); @(negedge clk);
      end
    end
    // DONE cycle: offer a legal load and a stray rvalid; neither may be taken.
    dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0;
    #1;
    done_ok = !lsu_stall && !dmem_req && !lsu_fault;
    @(posedge clk); @(negedge clk);
    ex_mem_read = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h40; ex_store_data = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if ({dmem_req, lsu_stall, lsu_fault} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: req/stall/fault got %b want 000", {dmem_req, lsu_stall, lsu_fault});
    end
    vectors++;
    if (mem_read_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_mrd: got %h want 00000000", mem_read_data);
    end
    vectors++;
    if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== 69'h0) begin
      miscompares++;
      $display("FAIL reset_latched: addr %h be %b wdata %h we %b want all 0", dmem_addr, dmem_be, dmem_wdata, dmem_we);
    end
    ex_mem_read = 1'b0;
    rst = 1'b0;
    exp_mrd = 32'h0;
  endtask

  task automatic test_lb();
    int sc; logic [3:0] be; logic [31:0] wa, wd; logic we, st, dn, to;
    @(negedge clk);
    drive_access(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF_0000,
                 sc, be, wa, wd, we, st, dn, to);
    exp_mrd = 32'hFFFF_FF80;
    vectors++; if (be !== 4'b1000) begin miscompares++; $display("FAIL lb_be: got %b want 1000", be); end
    vectors++; if (wa !== 32'h1000) begin miscompares++; $display("FAIL lb_addr: got %h want 00001000", wa); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL lb_we: got %b want 0", we); end
    vectors++; if (sc != 3) begin miscompares++; $display("FAIL lb_stall_cycles: got %0d want 3", sc); end
    vectors++; if ({st, dn, to} !== 3'b110) begin miscompares++; $display("FAIL lb_handshake: stable/done/timeout got %b want 110", {st, dn, to}); end
    vectors++; if (mem_read_data !== exp_mrd) begin miscompares++; $display("FAIL lb_data: got %h want %h", mem_read_data, exp_mrd); end
  endtask

  task automatic test_sh();
    int sc; logic [3:0] be; logic [31:0] wa, wd; logic we, st, dn, to;
    @(negedge clk);
    drive_access(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 0, 32'h0,
                 sc, be, wa, wd, we, st, dn, to);
    vectors++; if (be !== 4'b1100) begin miscompares++; $display("FAIL sh_be: got %b want 1100", be); end
    vectors++; if (wd !== 32'hBEEF_BEEF) begin miscompares++; $display("FAIL sh_wdata: got %h want beefbeef", wd); end
    vectors++; if (wa !== 32'h2000) begin miscompares++; $display("FAIL sh_addr: got %h want 00002000", wa); end
    vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL sh_we: got %b want 1", we); end
    vectors++; if (sc != 2) begin miscompares++; $display("FAIL sh_stall_cycles: got %0d want 2", sc); end
    vectors++; if ({st, dn, to} !== 3'b110) begin miscompares++; $display("FAIL sh_handshake: got %b want 110", {st, dn, to}); end
    vectors++; if (mem_read_data !== exp_mrd) begin miscompares++; $display("FAIL sh_mrd_kept: got %h want %h", mem_read_data, exp_mrd); end
  endtask

  task automatic test_lw_delayed();
    int sc; logic [3:0] be; logic [31:0] wa, wd, rdata; logic we, st, dn, to;
    rdata = $urandom;
    @(negedge clk);
    drive_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 2, rdata,
                 sc, be, wa, wd, we, st, dn, to);
    exp_mrd = rdata;
    vectors++; if ({st, dn, to} !== 3'b110) begin miscompares++; $display("FAIL lw_stable: got %b want 110", {st, dn, to}); end
    vectors++; if (wa !== 32'h10) begin miscompares++; $display("FAIL lw_addr: got %h want 00000010", wa); end
    vectors++; if (sc != 8) begin miscompares++; $display("FAIL lw_stall_cycles: got %0d want 8", sc); end
    vectors++; if (mem_read_data !== exp_mrd) begin miscompares++; $display("FAIL lw_data: got %h want %h", mem_read_data, exp_mrd); end
  endtask

  task automatic test_fault();
    @(negedge clk);
    ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b001; ex_addr = 32'h101;
    #1;
    vectors++;
    if ({lsu_fault, lsu_stall, dmem_req} !== 3'b100) begin
      miscompares++; $display("FAIL lh_fault: fault/stall/req got %b want 100", {lsu_fault, lsu_stall, dmem_req});
    end
    @(posedge clk); @(negedge clk);
    ex_mem_read = 1'b0;
    #1;
    vectors++;
    if ({lsu_fault, lsu_stall, dmem_req} !== 3'b000) begin
      miscompares++; $display("FAIL lh_fault_after: got %b want 000", {lsu_fault, lsu_stall, dmem_req});
    end
    vectors++;
    if (mem_read_data !== exp_mrd) begin
      miscompares++; $display("FAIL lh_fault_mrd: got %h want %h", mem_read_data, exp_mrd);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h40;
    @(posedge clk); @(negedge clk);
    ex_mem_read = 1'b0; dmem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_gnt = 1'b0; rst = 1'b1;
    #1;
    vectors++;
    if ({dmem_req, lsu_stall, lsu_fault} !== 3'b000) begin
      miscompares++; $display("FAIL rstmid_during: got %b want 000", {dmem_req, lsu_stall, lsu_fault});
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    exp_mrd = 32'h0;
    #1;
    vectors++;
    if ({dmem_req, lsu_stall} !== 2'b00) begin
      miscompares++; $display("FAIL rstmid_idle: req/stall got %b want 00", {dmem_req, lsu_stall});
    end
    @(posedge clk); @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    vectors++;
    if (mem_read_data !== exp_mrd) begin
      miscompares++; $display("FAIL rstmid_stray_rvalid: got %h want %h", mem_read_data, exp_mrd);
    end
  endtask

  task automatic test_back_to_back();
    int sc; logic [3:0] be; logic [31:0] wa, wd; logic we, st, dn, to;
    @(negedge clk);
    drive_access(1'b1, 1'b0, 3'b100, 32'h3, 32'h0, 0, 0, 32'hA1B2_C3D4,
                 sc, be, wa, wd, we, st, dn, to);
    vectors++; if (mem_read_data !== 32'h0000_00A1) begin miscompares++; $display("FAIL b2b_lbu: got %h want 000000a1", mem_read_data); end
    vectors++; if ({dn, sc} !== {1'b1, 32'd3}) begin miscompares++; $display("FAIL b2b_lbu_done: done %b stall %0d want 1/3", dn, sc); end
    drive_access(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 0, 0, 32'hA1B2_C3D4,
                 sc, be, wa, wd, we, st, dn, to);
    exp_mrd = 32'h0000_A1B2;
    vectors++; if (mem_read_data !== exp_mrd) begin miscompares++; $display("FAIL b2b_lhu: got %h want %h", mem_read_data, exp_mrd); end
    vectors++; if ({dn, sc} !== {1'b1, 32'd3}) begin miscompares++; $display("FAIL b2b_lhu_done: done %b stall %0d want 1/3", dn, sc); end
  endtask

  task automatic test_random();
    int sc, gd, rv, sel, sz, exp_sc;
    logic [3:0] be; logic [31:0] wa, wd, addr, sdata, rdata;
    logic we, st, dn, to, rd, wr;
    logic [2:0] f3;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      sel = $urandom_range(0, 9);
      rd = (sel == 0) || (sel >= 2 && sel <= 5);
      wr = (sel == 0) || (sel >= 6);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr && !rd) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end
      sz = size_of(f3);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2) addr[0] = 1'b0;
        if (sz == 4) addr[1:0] = 2'b00;
      end
      sdata = $urandom; rdata = $urandom;
      gd = $urandom_range(0, 3); rv = $urandom_range(0, 3);
      if (!rd && !wr) begin
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = f3; ex_addr = addr;
        #1;
        vectors++;
        if ({lsu_stall, lsu_fault, dmem_req} !== 3'b000) begin
          miscompares++; $display("FAIL rnd_idle[%0d]: got %b want 000", n, {lsu_stall, lsu_fault, dmem_req});
        end
        @(posedge clk);
      end else if (model_fault(rd, wr, f3, addr)) begin
        ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3; ex_addr = addr;
        #1;
        vectors++;
        if ({lsu_fault, lsu_stall, dmem_req} !== 3'b100) begin
          miscompares++;
          $display("FAIL rnd_fault[%0d]: rd %b wr %b f3 %0d addr %h got %b want 100", n, rd, wr, f3, addr, {lsu_fault, lsu_stall, dmem_req});
        end
        @(posedge clk); @(negedge clk);
        ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        #1;
        vectors++;
        if ({dmem_req, mem_read_data} !== {1'b0, exp_mrd}) begin
          miscompares++; $display("FAIL rnd_fault_after[%0d]: req %b mrd %h want 0 %h", n, dmem_req, mem_read_data, exp_mrd);
        end
      end else begin
        drive_access(rd, wr, f3, addr, sdata, gd, rv, rdata, sc, be, wa, wd, we, st, dn, to);
        exp_sc = 1 + (gd + 1) + (wr ? 0 : rv + 1);
        if (rd) exp_mrd = model_load(f3, addr, rdata);
        vectors++;
        if ({be, wa, we} !== {model_be(f3, addr), addr[31:2], 2'b00, wr}) begin
          miscompares++;
          $display("FAIL rnd_bus[%0d]: be %b addr %h we %b want %b %h %b", n, be, wa, we, model_be(f3, addr), {addr[31:2], 2'b00}, wr);
        end
        if (wr) begin
          vectors++;
          if (wd !== model_wdata(f3, sdata)) begin
            miscompares++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, wd, model_wdata(f3, sdata));
          end
        end
        vectors++;
        if ({st, dn, to} !== 3'b110 || sc != exp_sc) begin
          miscompares++;
          $display("FAIL rnd_handshake[%0d]: stable/done/timeout %b stall %0d want 110 %0d", n, {st, dn, to}, sc, exp_sc);
        end
        vectors++;
        if (mem_read_data !== exp_mrd) begin
          miscompares++; $display("FAIL rnd_mrd[%0d]: f3 %0d addr %h got %h want %h", n, f3, addr, mem_read_data, exp_mrd);
        end
      end
      ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_lw_delayed();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The interface SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ex_mem_read  input  1  load in MEM stage.
REQ-005 ex_mem_write  input  1  store in MEM stage.
REQ-006 ex_funct3  input  3  RV32I load/store width/sign code.
REQ-007 ex_addr  input  32  effective byte address (ALU result).
REQ-008 ex_store_data  input  32  rs2 value for stores.
REQ-009 dmem_req  output  1  bus request; held until granted.
REQ-010 dmem_we  output  1  1 = write.
REQ-011 dmem_addr  output  32  word address; {ex_addr[31:2],2'b00}.
REQ-012 dmem_be  output  4  byte enables.
REQ-013 dmem_wdata  output  32  lane-replicated store data.
REQ-014 dmem_gnt  input  1  request accepted this cycle.
REQ-015 dmem_rvalid  input  1  read data valid.
REQ-016 dmem_rdata  input  32  read data word.
REQ-017 mem_read_data  output  32  formatted load result, to MEM/WB register.
REQ-018 lsu_stall  output  1  freeze IF..MEM stages.
REQ-019 lsu_fault  output  1  misaligned/illegal access pulse.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, RESP, DONE.
REQ-021 An access SHALL be accepted in IDLE when exactly one of ex_mem_read/ex_mem_write is high and no fault condition holds; the block SHALL latch addr, funct3, be, wdata and dir, then go to REQ.
REQ-022 Fault conditions: both read and write high; halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 > 010.
REQ-023 On a fault in IDLE, lsu_fault SHALL be 1 combinationally that cycle, with no bus request, lsu_stall 0, and state remaining IDLE.
REQ-024 In REQ, dmem_req SHALL be 1 with the latched addr/be/wdata/we stable until dmem_gnt.
REQ-025 REQ with gnt: a store SHALL go to DONE; a load SHALL go to RESP.
REQ-026 In RESP, the block SHALL wait on dmem_rvalid; rvalid SHALL be ignored in every state except RESP.
REQ-027 RESP with rvalid: the block SHALL register the formatted data into mem_read_data and go to DONE.
REQ-028 DONE SHALL last one cycle with lsu_stall 0, no new acceptance, then go to IDLE.
REQ-029 lsu_stall SHALL equal (IDLE and accepting) or REQ or RESP.
REQ-030 Minimum latency from acceptance to DONE: store 2 cycles (gnt in first REQ cycle); load 3 cycles (rvalid in first RESP cycle).
REQ-031 Byte enables: SB 0001<<addr[1:0]; SH 0011<<{addr[1],1'b0}; SW 1111.
REQ-032 Store data: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-033 Load formatting: LB/LBU select byte addr[1:0], sign-/zero-extended; LH/LHU select half addr[1], sign-/zero-extended; LW passes the word.
REQ-034 mem_read_data SHALL hold its value until the next load completes; stores and faults SHALL not change it.

Reset
REQ-035 While rst=1, on the clock edge: state IDLE, mem_read_data 0, latched fields 0.
REQ-036 Reset mid-transaction (REQ/RESP) SHALL abort: dmem_req 0 from the next cycle, and a subsequent stray rvalid SHALL be ignored.
REQ-037 During reset, dmem_req, lsu_stall and lsu_fault SHALL be 0.

Verification
REQ-038 LB: addr 0x1003, rdata 0x80FF_0000, gnt and rvalid immediate -> be 1000, mem_read_data 0xFFFF_FF80, stall high for 3 cycles.
REQ-039 SH: addr 0x2002, data 0x0000_BEEF -> dmem_be 1100, wdata 0xBEEF_BEEF, dmem_addr 0x2000, we 1.
REQ-040 LW at addr 0x10, gnt delayed 3 cycles and rvalid delayed 2 cycles -> req and addr stable throughout, stall high until DONE, result equals rdata.
REQ-041 LH at addr 0x101 -> lsu_fault 1 for that cycle, no dmem_req, stall 0, mem_read_data unchanged.
REQ-042 rst asserted in RESP, then rvalid arrives -> IDLE, mem_read_data 0, no update.
REQ-043 Back-to-back loads LBU 0x3 then LHU 0x2 (rdata 0xA1B2_C3D4) -> 0x0000_00A1, then 0x0000_A1B2, each preceded by one DONE cycle.
